tri_span_gen: RTL and testbench

//  Triangle scan-converter and initiator on the req_2/ack_2 span interface. It accepts 3 packed vertices,

---
 rtl/tri_span_gen.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_tri_span_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_span_gen.sv
// -----------------------------------------------------------------------------
// tri_span_gen
//   Triangle scan-converter driving a z-buffered span filler over the
//   req_2/ack_2 handshake. Three vertices are latched, stably sorted by y,
//   and the long (s0->s2) and short (s0->s1, then s1->s2) edges are walked
//   one scanline at a time with integer error accumulators for x and z.
//   One span {long edge, short edge} is requested per scanline.
//
//   Optional feature macro: CULL_DEGENERATE_EN
//     defined   : triangles with all three y equal or all three x equal are
//                 acknowledged and finished without issuing any span.
//     undefined : degenerate triangles are walked like any other.
// -----------------------------------------------------------------------------
module tri_span_gen #(
    parameter int COORD_W       = 8,
    parameter int ACK_TO_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tri_req,
    output logic                   tri_ack,
    input  logic [3*COORD_W-1:0]   v0,
    input  logic [3*COORD_W-1:0]   v1,
    input  logic [3*COORD_W-1:0]   v2,
    output logic                   tri_done,
    output logic                   busy,
    output logic                   err,
    output logic                   req_2,
    input  logic                   ack_2,
    output logic [3*COORD_W-1:0]   point_out_a,
    output logic [3*COORD_W-1:0]   point_out_b
);

    localparam int PW   = 3 * COORD_W;
    localparam int WD_W = (ACK_TO_CYCLES > 1) ? $clog2(ACK_TO_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (ACK_TO_CYCLES > 0) ? WD_W'(ACK_TO_CYCLES - 1) : '0;

    typedef logic [PW-1:0]      point_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   acc_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SORT, S_SETUP, S_EMIT_REQ, S_EMIT_WAIT, S_STEP, S_DONE
    } state_t;

    // One edge walker: current x/z, magnitudes, step directions, error terms.
    typedef struct packed {
        coord_t x;
        coord_t z;
        coord_t dy;
        coord_t dx;
        coord_t dz;
        logic   neg_x;
        logic   neg_z;
        acc_t   acc_x;
        acc_t   acc_z;
    } edge_t;

    function automatic coord_t px(input point_t p);
        return p[PW-1:2*COORD_W];
    endfunction

    function automatic coord_t py(input point_t p);
        return p[2*COORD_W-1:COORD_W];
    endfunction

    function automatic coord_t pz(input point_t p);
        return p[COORD_W-1:0];
    endfunction

    function automatic edge_t make_edge(input point_t ps, input point_t pe);
        edge_t e;
        e       = '0;
        e.x     = px(ps);
        e.z     = pz(ps);
        e.dy    = py(pe) - py(ps);
        e.neg_x = px(pe) < px(ps);
        e.neg_z = pz(pe) < pz(ps);
        e.dx    = e.neg_x ? (px(ps) - px(pe)) : (px(pe) - px(ps));
        e.dz    = e.neg_z ? (pz(ps) - pz(pe)) : (pz(pe) - pz(ps));
        return e;
    endfunction

    // Add one scanline's worth of error; a zero-height edge never moves.
    function automatic edge_t accumulate(input edge_t e);
        edge_t r;
        r = e;
        if (e.dy != '0) begin
            r.acc_x = e.acc_x + {1'b0, e.dx};
            r.acc_z = e.acc_z + {1'b0, e.dz};
        end
        return r;
    endfunction

    function automatic logic x_due(input edge_t e);
        return (e.dy != '0) && (e.acc_x >= {1'b0, e.dy});
    endfunction

    function automatic logic z_due(input edge_t e);
        return (e.dy != '0) && (e.acc_z >= {1'b0, e.dy});
    endfunction

    function automatic edge_t step_edge(input edge_t e);
        edge_t r;
        r = e;
        if (x_due(e)) begin
            r.x     = e.neg_x ? (e.x - coord_t'(1)) : (e.x + coord_t'(1));
            r.acc_x = e.acc_x - {1'b0, e.dy};
        end
        if (z_due(e)) begin
            r.z     = e.neg_z ? (e.z - coord_t'(1)) : (e.z + coord_t'(1));
            r.acc_z = e.acc_z - {1'b0, e.dy};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release is clocked.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    // Shift ones in behind the release of rst.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Two-stage release register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    point_t     vtx_q [3];
    point_t     vtx_d [3];
    point_t     srt_q [3];
    point_t     srt_d [3];
    edge_t      long_q, long_d;
    edge_t      short_q, short_d;
    logic       short_upper_q, short_upper_d;
    coord_t     y_q, y_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic       tri_ack_q, tri_ack_d;
    logic       tri_done_q, tri_done_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       req_2_q, req_2_d;

    point_t     sorted [3];
    logic [1:0] rank [3];
    coord_t     y_next;
    logic       cull;

    // Stable rank by y: earlier inputs win ties.
    always_comb begin
        // NOTE: every combinational output gets a value before any branch so no latch is inferred.
        for (int i = 0; i < 3; i++) begin
            rank[i] = 2'd0;
            for (int j = 0; j < 3; j++) begin
                if ((py(vtx_q[j]) < py(vtx_q[i])) ||
                    ((py(vtx_q[j]) == py(vtx_q[i])) && (j < i))) begin
                    rank[i] = rank[i] + 2'd1;
                end
            end
        end
        for (int i = 0; i < 3; i++) sorted[i] = '0;
        for (int i = 0; i < 3; i++) sorted[rank[i]] = vtx_q[i];
    end

`ifdef CULL_DEGENERATE_EN
    assign cull = ((py(vtx_q[0]) == py(vtx_q[1])) && (py(vtx_q[1]) == py(vtx_q[2]))) ||
                  ((px(vtx_q[0]) == px(vtx_q[1])) && (px(vtx_q[1]) == px(vtx_q[2])));
`else
    assign cull = 1'b0;
`endif

    assign y_next = y_q + coord_t'(1);

    // Next-state, edge walking and handshake control.
    always_comb begin
        state_d       = state_q;
        vtx_d         = vtx_q;
        srt_d         = srt_q;
        long_d        = long_q;
        short_d       = short_q;
        short_upper_d = short_upper_q;
        y_d           = y_q;
        wd_d          = wd_q;
        tri_ack_d     = 1'b0;
        tri_done_d    = 1'b0;
        busy_d        = busy_q;
        err_d         = err_q;
        req_2_d       = req_2_q;

        case (state_q)
            S_IDLE: begin
                if (tri_req) begin
                    vtx_d     = '{v0, v1, v2};
                    tri_ack_d = 1'b1;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    state_d   = S_SORT;
                end
            end

            S_SORT: begin
                srt_d = sorted;
                if (cull) begin
                    tri_done_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                long_d = make_edge(srt_q[0], srt_q[2]);
                if (py(srt_q[0]) == py(srt_q[1])) begin
                    short_d       = make_edge(srt_q[1], srt_q[2]);
                    short_upper_d = 1'b1;
                end else begin
                    short_d       = make_edge(srt_q[0], srt_q[1]);
                    short_upper_d = 1'b0;
                end
                y_d     = py(srt_q[0]);
                wd_d    = '0;
                req_2_d = 1'b1;
                state_d = S_EMIT_REQ;
            end

            S_EMIT_REQ: begin
                if (ack_2) begin
                    req_2_d = 1'b0;
                    state_d = S_EMIT_WAIT;
                end else if ((ACK_TO_CYCLES > 0) && (wd_q == WD_LAST)) begin
                    req_2_d    = 1'b0;
                    err_d      = 1'b1;
                    tri_done_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            S_EMIT_WAIT: begin
                if (!ack_2) begin
                    if (y_q == py(srt_q[2])) begin
                        tri_done_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        y_d    = y_next;
                        long_d = accumulate(long_q);
                        if (!short_upper_q && (y_next == py(srt_q[1]))) begin
                            short_d       = make_edge(srt_q[1], srt_q[2]);
                            short_upper_d = 1'b1;
                        end else begin
                            short_d = accumulate(short_q);
                        end
                        state_d = S_STEP;
                    end
                end
            end

            S_STEP: begin
                if (x_due(long_q) || z_due(long_q) || x_due(short_q) || z_due(short_q)) begin
                    long_d  = step_edge(long_q);
                    short_d = step_edge(short_q);
                end else begin
                    wd_d    = '0;
                    req_2_d = 1'b1;
                    state_d = S_EMIT_REQ;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Vertex holding registers.
    always_ff @(posedge clk) begin
        // NOTE: vertex holding registers carry no reset; they are always written before being read.
        vtx_q <= vtx_d;
        srt_q <= srt_d;
    end

    // Control and edge-walker registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= S_IDLE;
            long_q        <= '0;
            short_q       <= '0;
            short_upper_q <= 1'b0;
            y_q           <= '0;
            wd_q          <= '0;
            tri_ack_q     <= 1'b0;
            tri_done_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            req_2_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            long_q        <= long_d;
            short_q       <= short_d;
            short_upper_q <= short_upper_d;
            y_q           <= y_d;
            wd_q          <= wd_d;
            tri_ack_q     <= tri_ack_d;
            tri_done_q    <= tri_done_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            req_2_q       <= req_2_d;
        end
    end

    assign tri_ack     = tri_ack_q;
    assign tri_done    = tri_done_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign req_2       = req_2_q;
    assign point_out_a = {long_q.x, y_q, long_q.z};
    assign point_out_b = {short_q.x, y_q, short_q.z};

endmodule

// File: tb/tb_tri_span_gen.sv
// -----------------------------------------------------------------------------
// tb_tri_span_gen
//   Scoreboard bench for tri_span_gen. Expected spans come from a closed-form
//   interpolation model (start + sign * floor(d*k/dy)) and are queued when a
//   triangle is issued; a filler model pops and compares one entry per span
//   request and checks the req_2/ack_2 handshake timing.
// -----------------------------------------------------------------------------
module tb_tri_span_gen;

    localparam int CW     = 8;
    localparam int PW     = 3 * CW;
    localparam int ACK_TO = 16;

`ifdef CULL_DEGENERATE_EN
    localparam bit CULL_ON = 1'b1;
`else
    localparam bit CULL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tri_req;
    logic          tri_ack;
    logic [PW-1:0] v0, v1, v2;
    logic          tri_done;
    logic          busy;
    logic          err;
    logic          req_2;
    logic          ack_2;
    logic [PW-1:0] point_out_a;
    logic [PW-1:0] point_out_b;

    always #5 clk = ~clk;

    tri_span_gen #(
        .COORD_W       (CW),
        .ACK_TO_CYCLES (ACK_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tri_req     (tri_req),
        .tri_ack     (tri_ack),
        .v0          (v0),
        .v1          (v1),
        .v2          (v2),
        .tri_done    (tri_done),
        .busy        (busy),
        .err         (err),
        .req_2       (req_2),
        .ack_2       (ack_2),
        .point_out_a (point_out_a),
        .point_out_b (point_out_b)
    );

    typedef struct {
        logic [PW-1:0] a;
        logic [PW-1:0] b;
    } span_t;

    span_t sb[$];
    int    checks    = 0;
    int    errors    = 0;
    bit    filler_en = 1'b1;
    bit    gap_chk   = 1'b0;
    int    span_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gx(input logic [PW-1:0] p);
        return int'(p[PW-1:2*CW]);
    endfunction

    function automatic int gy(input logic [PW-1:0] p);
        return int'(p[2*CW-1:CW]);
    endfunction

    function automatic int gz(input logic [PW-1:0] p);
        return int'(p[CW-1:0]);
    endfunction

    function automatic logic [PW-1:0] mk(input int x, input int y, input int z);
        return {CW'(x), CW'(y), CW'(z)};
    endfunction

    function automatic int interp(input int c0, input int c1, input int k, input int dy);
        if (dy == 0) return c0;
        if (c1 >= c0) return c0 + ((c1 - c0) * k) / dy;
        return c0 - ((c0 - c1) * k) / dy;
    endfunction

    // Queue every expected span of a triangle.
    task automatic push_model(input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [PW-1:0] p2);
        logic [PW-1:0] s [3];
        logic [PW-1:0] tmp;
        span_t         sp;
        int            ax, az, bx, bz;
        s = '{p0, p1, p2};
        for (int i = 1; i < 3; i++) begin
            for (int j = i; j > 0; j--) begin
                if (gy(s[j-1]) > gy(s[j])) begin
                    tmp = s[j-1]; s[j-1] = s[j]; s[j] = tmp;
                end
            end
        end
        for (int y = gy(s[0]); y <= gy(s[2]); y++) begin
            ax = interp(gx(s[0]), gx(s[2]), y - gy(s[0]), gy(s[2]) - gy(s[0]));
            az = interp(gz(s[0]), gz(s[2]), y - gy(s[0]), gy(s[2]) - gy(s[0]));
            if (y < gy(s[1])) begin
                bx = interp(gx(s[0]), gx(s[1]), y - gy(s[0]), gy(s[1]) - gy(s[0]));
                bz = interp(gz(s[0]), gz(s[1]), y - gy(s[0]), gy(s[1]) - gy(s[0]));
            end else begin
                bx = interp(gx(s[1]), gx(s[2]), y - gy(s[1]), gy(s[2]) - gy(s[1]));
                bz = interp(gz(s[1]), gz(s[2]), y - gy(s[1]), gy(s[2]) - gy(s[1]));
            end
            sp.a = mk(ax, y, az);
            sp.b = mk(bx, y, bz);
            sb.push_back(sp);
        end
    endtask

    // Filler model: ack_2 rises 3 cycles after req_2 is seen and stays high 7 cycles.
    typedef enum int {F_IDLE, F_DELAY, F_ACK} fst_t;

    initial begin
        fst_t          f_st;
        int            f_cnt;
        logic [2*PW-1:0] cap;
        span_t         e;
        ack_2 = 1'b0;
        f_st  = F_IDLE;
        f_cnt = 0;
        cap   = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                ack_2   = 1'b0;
                gap_chk = 1'b0;
                f_st    = F_IDLE;
                continue;
            end
            case (f_st)
                F_IDLE: begin
                    if (gap_chk) begin
                        check("req_gap_after_ack_fall", req_2, 1'b0);
                        gap_chk = 1'b0;
                    end else if (filler_en && req_2) begin
                        cap = {point_out_a, point_out_b};
                        span_cnt++;
                        check("sb_has_span", sb.size() != 0, 1'b1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("span_a", point_out_a, e.a);
                            check("span_b", point_out_b, e.b);
                        end
                        f_cnt = 0;
                        f_st  = F_DELAY;
                    end
                end
                F_DELAY: begin
                    check("req_hold", req_2, 1'b1);
                    check("pt_stable_req", {point_out_a, point_out_b}, cap);
                    f_cnt++;
                    if (f_cnt == 3) begin
                        ack_2 = 1'b1;
                        f_cnt = 0;
                        f_st  = F_ACK;
                    end
                end
                F_ACK: begin
                    check("req_drop_after_ack", req_2, 1'b0);
                    check("pt_stable_ack", {point_out_a, point_out_b}, cap);
                    f_cnt++;
                    if (f_cnt == 7) begin
                        ack_2   = 1'b0;
                        gap_chk = 1'b1;
                        f_st    = F_IDLE;
                    end
                end
                default: f_st = F_IDLE;
            endcase
        end
    end

    // Issue one triangle and follow it to tri_done. Called on a negedge.
    task automatic run_tri(input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                           input bit expect_to, input int hold);
        bit cull;
        bit seen;
        int req_hi;
        int extra_ack;
        cull = CULL_ON && (((gy(p0) == gy(p1)) && (gy(p1) == gy(p2))) ||
                           ((gx(p0) == gx(p1)) && (gx(p1) == gx(p2))));
        if (!expect_to && !cull) push_model(p0, p1, p2);
        v0 = p0; v1 = p1; v2 = p2;
        tri_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tri_ack) begin seen = 1'b1; break; end
        end
        check("tri_ack_seen", seen, 1'b1);
        check("busy_at_ack", busy, 1'b1);
        check("err_clr_at_ack", err, 1'b0);
        if (hold > 0) v0 = mk(200, 0, 200);
        req_hi = 0;
        extra_ack = 0;
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (c >= hold) tri_req = 1'b0;
            @(negedge clk);
            if (req_2) req_hi++;
            if (tri_ack) extra_ack++;
            if (tri_done) begin seen = 1'b1; break; end
        end
        tri_req = 1'b0;
        check("tri_done_seen", seen, 1'b1);
        check("busy_at_done", busy, 1'b1);
        check("err_at_done", err, expect_to);
        check("no_extra_ack", extra_ack, 0);
        check("spans_left", sb.size(), 0);
        if (expect_to) check("req_hi_cycles_timeout", req_hi, ACK_TO);
        else if (cull) check("req_hi_cycles_cull", req_hi, 0);
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);
        check("done_single_pulse", tri_done, 1'b0);
        sb.delete();
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        tri_req = 1'b0;
        v0 = '0; v1 = '0; v2 = '0;
        repeat (3) @(negedge clk);
        check("rst_tri_ack", tri_ack, 1'b0);
        check("rst_tri_done", tri_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_req_2", req_2, 1'b0);
        check("rst_point_a", point_out_a, '0);
        check("rst_point_b", point_out_b, '0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Flat top, tri_req held high while busy.
        run_tri(mk(10, 2, 40), mk(14, 2, 40), mk(10, 6, 40), 1'b0, 4);
        // Unsorted input, short edge reloads at y1.
        run_tri(mk(0, 9, 0), mk(0, 1, 0), mk(8, 5, 80), 1'b0, 0);
        // Zero-height triangle.
        run_tri(mk(3, 7, 0), mk(9, 7, 0), mk(5, 7, 0), 1'b0, 0);

        // Ack timeout with the filler silent.
        filler_en = 1'b0;
        run_tri(mk(1, 1, 1), mk(20, 4, 9), mk(5, 9, 3), 1'b1, 0);
        repeat (5) @(negedge clk);
        check("err_sticky", err, 1'b1);
        filler_en = 1'b1;
        run_tri(mk(10, 2, 40), mk(14, 2, 40), mk(10, 6, 40), 1'b0, 0);

        // Random triangles.
        for (int t = 0; t < 3; t++) begin
            run_tri(mk($urandom_range(0, 255), $urandom_range(0, 30), $urandom_range(0, 255)),
                    mk($urandom_range(0, 255), $urandom_range(0, 30), $urandom_range(0, 255)),
                    mk($urandom_range(0, 255), $urandom_range(0, 30), $urandom_range(0, 255)),
                    1'b0, 0);
        end

        // Reset while waiting for ack_2 to fall on the third span.
        span_cnt = 0;
        push_model(mk(0, 9, 0), mk(0, 1, 0), mk(8, 5, 80));
        v0 = mk(0, 9, 0); v1 = mk(0, 1, 0); v2 = mk(8, 5, 80);
        tri_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tri_ack) begin seen = 1'b1; break; end
        end
        check("t6_tri_ack_seen", seen, 1'b1);
        tri_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            if ((span_cnt == 3) && ack_2 && !req_2) begin seen = 1'b1; break; end
        end
        check("t6_reached_span3_wait", seen, 1'b1);
        check("t6_busy_before_rst", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("t6_rst_req_2", req_2, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_tri_done", tri_done, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_post_rst_busy", busy, 1'b0);
        check("t6_post_rst_req_2", req_2, 1'b0);
        run_tri(mk(10, 2, 40), mk(14, 2, 40), mk(10, 6, 40), 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
